ddr_req_arbiter: RTL

//  Sequences the shared DDR2 controller port between two requesters: ring memory ops (memOpQ + writeDataQ) and display-controller line reads.

---
 rtl/ddr_arb_pkg.sv | 13 +
 rtl/arb_tag_fifo.sv | 40 ++++
 rtl/ddr_req_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared widths, op-bit index, tag layout and return FSM states for ddr_req_arbiter
package ddr_arb_pkg;
  localparam int ADDR_W = 26;
  localparam int READ_BIT = 28;
  typedef struct packed {
    logic isDc;
    logic [3:0] dest;
  } tagT;
  typedef enum logic {
    RET_IDLE = 1'b0,
    RET_BEAT = 1'b1
  } retStateT;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: FWFT tag FIFO of outstanding reads; push and pop may coincide even when full
module arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic clock,
  input  logic resetB,
  input  logic push,
  input  logic pop,
  input  tagT  din,
  output tagT  dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  tagT mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] count;
  logic doPush, doPop;
  assign doPop = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rdPtr];
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
    end
  end
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= din;
  end
endmodule

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter: arbitrates ring ops and display reads onto the DDR AF/WB port and routes RB data back.
// Define ARB_STATS_EN to build the grant/stall statistics counters.
module ddr_req_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DC_MAX_WAIT = 16,
  parameter int TAG_DEPTH = 32
) (
  input  logic              clock,
  input  logic              resetB,
  input  logic              memOpQempty,
  input  logic [3:0]        memOpDest,
  input  logic [31:0]       memOpData,
  output logic              rdMemOp,
  input  logic              writeDataQempty,
  input  logic [127:0]      writeDataIn,
  output logic              rdWriteData,
  input  logic              dcReq,
  input  logic [ADDR_W-1:0] dcAddr,
  output logic              dcAck,
  input  logic              afFull,
  input  logic              wbFull,
  output logic              wrAF,
  output logic [ADDR_W-1:0] afAddress,
  output logic              afRead,
  output logic              wrWB,
  output logic [127:0]      writeData,
  input  logic              rbEmpty,
  input  logic [127:0]      readData,
  output logic              rdRB,
  output logic [31:0]       RDreturn,
  output logic [3:0]        RDdest,
  output logic [127:0]      RDtoDC,
  output logic              wrRDtoDC,
  output logic [15:0]       statRing,
  output logic [15:0]       statDC,
  output logic [15:0]       statStall
);
  localparam int WW = $clog2(DC_MAX_WAIT);
  tagT tagIn, tagOut;
  retStateT state, stateNext;
  logic [WW-1:0] waitCnt;
  logic [1:0] beatCnt;
  logic [127:0] retData;
  logic tagPush, tagPop, tagFull, tagEmpty, tagOk, opRead;
  logic ringRdElig, ringWrElig, ringElig, dcElig, dcForce;
  logic grantDc, grantRing, grantWr, unusedBits;

  assign opRead = memOpData[READ_BIT];
  assign unusedBits = ^{memOpData[31:READ_BIT+1], memOpData[READ_BIT-1:ADDR_W]};
  // a tag freed by this cycle's RB pop is immediately reusable
  assign tagOk = ~tagFull | tagPop;
  assign ringRdElig = ~memOpQempty & opRead & tagOk & ~afFull;
  assign ringWrElig = ~memOpQempty & ~opRead & ~writeDataQempty & ~wbFull & ~afFull;
  assign ringElig = ringRdElig | ringWrElig;
  assign dcElig = dcReq & tagOk & ~afFull;
  assign dcForce = waitCnt == WW'(DC_MAX_WAIT - 1);
  assign grantDc = dcElig & (dcForce | ~ringElig);
  assign grantRing = ringElig & ~grantDc;
  assign grantWr = grantRing & ~opRead;
  assign rdMemOp = grantRing;
  assign rdWriteData = grantWr;
  assign dcAck = grantDc;
  assign tagPush = grantDc | (grantRing & opRead);
  assign tagIn = '{isDc: grantDc, dest: grantDc ? 4'd0 : memOpDest};
  assign rdRB = tagPop;

  arb_tag_fifo #(.DEPTH(TAG_DEPTH)) tagFifo (
    .clock(clock),
    .resetB(resetB),
    .push(tagPush),
    .pop(tagPop),
    .din(tagIn),
    .dout(tagOut),
    .full(tagFull),
    .empty(tagEmpty)
  );

  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) waitCnt <= '0;
    else if (!dcReq || grantDc) waitCnt <= '0;
    else if (dcElig && !dcForce) waitCnt <= waitCnt + 1'b1;
  end

  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      wrAF <= 1'b0;
      wrWB <= 1'b0;
      afAddress <= '0;
      afRead <= 1'b0;
      writeData <= '0;
    end else begin
      wrAF <= grantRing | grantDc;
      wrWB <= grantWr;
      if (grantRing || grantDc) begin
        afAddress <= grantDc ? dcAddr : memOpData[ADDR_W-1:0];
        afRead <= ~grantWr;
      end
      if (grantWr) writeData <= writeDataIn;
    end
  end

  always_comb begin
    tagPop = state == RET_IDLE && !rbEmpty && !tagEmpty;
    stateNext = state == RET_IDLE ? (tagPop && !tagOut.isDc ? RET_BEAT : RET_IDLE)
                                  : (beatCnt == 2'd3 ? RET_IDLE : RET_BEAT);
  end

  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) state <= RET_IDLE;
    else state <= stateNext;
  end

  // beat 0 leaves straight from the pop; RDdest holds through the burst
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      retData <= '0;
      beatCnt <= '0;
      RDreturn <= '0;
      RDdest <= '0;
      RDtoDC <= '0;
      wrRDtoDC <= 1'b0;
    end else if (tagPop) begin
      retData <= readData;
      beatCnt <= 2'd1;
      RDreturn <= tagOut.isDc ? 32'h0 : readData[31:0];
      RDdest <= tagOut.isDc ? 4'd0 : tagOut.dest;
      wrRDtoDC <= tagOut.isDc;
      if (tagOut.isDc) RDtoDC <= readData;
    end else if (state == RET_BEAT) begin
      RDreturn <= retData[{beatCnt, 5'b0} +: 32];
      beatCnt <= beatCnt + 1'b1;
      wrRDtoDC <= 1'b0;
    end else begin
      RDreturn <= '0;
      RDdest <= '0;
      wrRDtoDC <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  logic stall;
  assign stall = (~memOpQempty & opRead & (afFull | ~tagOk))
               | (~memOpQempty & ~opRead & ~writeDataQempty & (afFull | wbFull))
               | (dcReq & (afFull | ~tagOk));
  always_ff @(posedge clock or negedge resetB) begin
    if (!resetB) begin
      statRing <= '0;
      statDC <= '0;
      statStall <= '0;
    end else begin
      statRing <= statRing + {15'b0, grantRing & ~&statRing};
      statDC <= statDC + {15'b0, grantDc & ~&statDC};
      statStall <= statStall + {15'b0, stall & ~&statStall};
    end
  end
`else
  assign statRing = 16'h0;
  assign statDC = 16'h0;
  assign statStall = 16'h0;
`endif
endmodule
